// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width, mode encoding
// and a bit-reversal helper used to run left shifts through a right shifter.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_mode_e;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// 32-bit logarithmic barrel shifter (SLL/SRL/SRA); purely combinational, 0 cycles.
// No flow control: output follows inputs every cycle.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] i_data,
    input  logic [4:0]      i_shamt,
    input  logic            i_right,
    input  logic            i_arith,
    output logic [XLEN-1:0] o_result
);

    logic            w_fill;
    logic [XLEN-1:0] w_stage [0:5];

    // Left shifts reuse the right-shift stages on a bit-reversed operand.
    assign w_fill     = i_right & i_arith & i_data[XLEN-1];
    assign w_stage[0] = i_right ? i_data : bit_reverse(i_data);

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign w_stage[k+1] = i_shamt[k] ? {{SH{w_fill}}, w_stage[k][XLEN-1:SH]}
                                         : w_stage[k];
    end

    assign o_result = i_right ? w_stage[5] : bit_reverse(w_stage[5]);

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: ten RISC-V style ops, combinational X/zero (0 cycles) plus
// X_q/zero_q registered copies (1 cycle). No handshake; every cycle is valid.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      mode,
    output logic [XLEN-1:0] X,
    output logic            zero,
    output logic [XLEN-1:0] X_q,
    output logic            zero_q
);

    logic            w_is_sub;
    logic [XLEN-1:0] w_b_op;
    logic [XLEN:0]   w_sum_ext;
    logic [XLEN-1:0] w_sum;
    logic            w_carry;
    logic            w_overflow;
    logic            w_lt_signed;
    logic            w_lt_unsigned;
    logic            w_shift_right;
    logic            w_shift_arith;
    logic [XLEN-1:0] w_shift_res;
    logic [XLEN-1:0] w_x;
    logic [XLEN-1:0] r_x_q;
    logic            r_zero_q;

    // One adder serves ADD, SUB and both compares; everything but ADD subtracts.
    assign w_is_sub  = (mode != ALU_ADD);
    assign w_b_op    = w_is_sub ? ~B : B;
    assign w_sum_ext = {1'b0, A} + {1'b0, w_b_op} + {{XLEN{1'b0}}, w_is_sub};
    assign w_sum     = w_sum_ext[XLEN-1:0];
    assign w_carry   = w_sum_ext[XLEN];

    // A - B: no carry out means a borrow, i.e. unsigned A < B.
    assign w_overflow    = (A[XLEN-1] == w_b_op[XLEN-1]) && (w_sum[XLEN-1] != A[XLEN-1]);
    assign w_lt_signed   = w_sum[XLEN-1] ^ w_overflow;
    assign w_lt_unsigned = ~w_carry;

    assign w_shift_right = (mode == ALU_SRL) || (mode == ALU_SRA);
    assign w_shift_arith = (mode == ALU_SRA);

    alu_shifter u_shifter (
        .i_data   (A),
        .i_shamt  (B[4:0]),
        .i_right  (w_shift_right),
        .i_arith  (w_shift_arith),
        .o_result (w_shift_res)
    );

    always_comb begin
        w_x = '0;
        case (mode)
            ALU_ADD,
            ALU_SUB:  w_x = w_sum;
            ALU_AND:  w_x = A & B;
            ALU_OR:   w_x = A | B;
            ALU_XOR:  w_x = A ^ B;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  w_x = w_shift_res;
            ALU_SLT:  w_x = {{(XLEN-1){1'b0}}, w_lt_signed};
            ALU_SLTU: w_x = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            default:  w_x = '0;
        endcase
    end

    assign X    = w_x;
    assign zero = (w_x == '0);

    // zero_q resets to 0 even though X_q resets to 0: the flag is cleared, not derived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_q    <= '0;
            r_zero_q <= 1'b0;
        end else begin
            r_x_q    <= w_x;
            r_zero_q <= zero;
        end
    end

    assign X_q    = r_x_q;
    assign zero_q = r_zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, randomized ops against a
// behavioural model, register latency and asynchronous reset behaviour.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  mode;
    logic [31:0] X;
    logic        zero;
    logic [31:0] X_q;
    logic        zero_q;

    int n_checks;
    int n_pass;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .mode   (mode),
        .X      (X),
        .zero   (zero),
        .X_q    (X_q),
        .zero_q (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] m);
        logic [4:0] sh;
        sh = b[4:0];
        case (m)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  m;
        logic [31:0] x;
    } vec_t;

    task automatic test_reset();
        rst_n = 1'b0;
        A = 32'h0000_0001; B = 32'h0000_0002; mode = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (X_q !== 32'd0 || zero_q !== 1'b0)
            $display("FAIL reset_state: X_q=%h zero_q=%b required X_q=0 zero_q=0", X_q, zero_q);
        else n_pass++;
        n_checks++;
        if (X !== 32'd3)
            $display("FAIL reset_comb: X=%h required 00000003", X);
        else n_pass++;
    endtask

    task automatic test_directed();
        vec_t v[18];
        v[0]  = '{32'h0000_0001, 32'h0000_0002, 4'd0,  32'h0000_0003};
        v[1]  = '{32'h0000_000A, 32'h0000_0020, 4'd1,  32'hFFFF_FFEA};
        v[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd0,  32'h0000_0000};
        v[3]  = '{32'h0000_00CC, 32'h0000_00CA, 4'd2,  32'h0000_00C8};
        v[4]  = '{32'h0000_00CC, 32'h0000_00CA, 4'd3,  32'h0000_00CE};
        v[5]  = '{32'h0000_00CC, 32'h0000_00CA, 4'd4,  32'h0000_0006};
        v[6]  = '{32'h0000_00CC, 32'h0000_0002, 4'd5,  32'h0000_0330};
        v[7]  = '{32'h0000_00CC, 32'h0000_0002, 4'd6,  32'h0000_0033};
        v[8]  = '{32'h0000_00CC, 32'h0000_0002, 4'd7,  32'h0000_0033};
        v[9]  = '{32'h8000_0000, 32'h0000_0004, 4'd7,  32'hF800_0000};
        v[10] = '{32'h8000_0000, 32'h0000_0004, 4'd6,  32'h0800_0000};
        v[11] = '{32'h0000_00CC, 32'h0000_0022, 4'd5,  32'h0000_0330};
        v[12] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd8,  32'h0000_0001};
        v[13] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd9,  32'h0000_0000};
        v[14] = '{32'h0000_0005, 32'h0000_0005, 4'd8,  32'h0000_0000};
        v[15] = '{32'h1234_5678, 32'h9ABC_DEF0, 4'd12, 32'h0000_0000};
        v[16] = '{32'h8000_0001, 32'h0000_0020, 4'd7,  32'h8000_0001};
        v[17] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  32'h8000_0000};
        for (int i = 0; i < 18; i++) begin
            A = v[i].a; B = v[i].b; mode = v[i].m;
            #1;
            n_checks++;
            if (X !== v[i].x || zero !== (v[i].x == 32'd0))
                $display("FAIL directed[%0d]: X=%h zero=%b required X=%h zero=%b",
                         i, X, zero, v[i].x, (v[i].x == 32'd0));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_x;
        for (int i = 0; i < 400; i++) begin
            A = $urandom;
            B = $urandom;
            mode = 4'($urandom_range(0, 15));
            if (i % 8 == 0) B = A;
            if (i % 16 == 3) A = 32'h8000_0000;
            if (i % 16 == 5) B = 32'h7FFF_FFFF;
            #1;
            exp_x = ref_alu(A, B, mode);
            n_checks++;
            if (X !== exp_x || zero !== (exp_x == 32'd0))
                $display("FAIL random mode=%0d A=%h B=%h: X=%h zero=%b required X=%h zero=%b",
                         mode, A, B, X, zero, exp_x, (exp_x == 32'd0));
            else n_pass++;
        end
    endtask

    task automatic test_registers();
        @(negedge clk);
        rst_n = 1'b1;
        A = 32'd1; B = 32'd2; mode = 4'd0;
        @(posedge clk); #1;
        n_checks++;
        if (X_q !== 32'd3 || zero_q !== 1'b0)
            $display("FAIL reg_add: X_q=%h zero_q=%b required 00000003/0", X_q, zero_q);
        else n_pass++;

        A = 32'd0; B = 32'd0; mode = 4'd0;
        #2;
        n_checks++;
        if (X_q !== 32'd3 || zero_q !== 1'b0)
            $display("FAIL reg_hold: X_q=%h zero_q=%b required 00000003/0", X_q, zero_q);
        else n_pass++;

        @(posedge clk); #1;
        n_checks++;
        if (X_q !== 32'd0 || zero_q !== 1'b1)
            $display("FAIL reg_zero: X_q=%h zero_q=%b required 00000000/1", X_q, zero_q);
        else n_pass++;

        A = 32'd1; B = 32'd2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (X_q !== 32'd0 || zero_q !== 1'b0)
            $display("FAIL async_reset: X_q=%h zero_q=%b required 00000000/0", X_q, zero_q);
        else n_pass++;
        n_checks++;
        if (X !== 32'd3 || zero !== 1'b0)
            $display("FAIL comb_in_reset: X=%h zero=%b required 00000003/0", X, zero);
        else n_pass++;

        @(posedge clk); #1;
        n_checks++;
        if (X_q !== 32'd0)
            $display("FAIL reset_held: X_q=%h required 00000000", X_q);
        else n_pass++;

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (X_q !== 32'd0)
            $display("FAIL release_no_edge: X_q=%h required 00000000", X_q);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            A = $urandom;
            B = (i % 5 == 0) ? A : $urandom;
            mode = 4'($urandom_range(0, 15));
            exp_x = ref_alu(A, B, mode);
            @(posedge clk); #1;
            n_checks++;
            if (X_q !== exp_x || zero_q !== (exp_x == 32'd0))
                $display("FAIL back_to_back[%0d] mode=%0d: X_q=%h zero_q=%b required X_q=%h zero_q=%b",
                         i, mode, X_q, zero_q, exp_x, (exp_x == 32'd0));
            else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        A = '0; B = '0; mode = '0;
        test_reset();
        test_directed();
        test_random();
        test_registers();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
